// File: rtl/axis_in_gather_pkg.sv
// Shared types and sizing helpers for the column gatherer.
package axis_in_gather_pkg;

    // Gatherer control states: take columns, fill with zero columns, present word.
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        PAD     = 2'd1,
        HOLD    = 2'd2
    } state_e;

    // Default geometry used when the block is built stand-alone.
    localparam int DEF_ROWS       = 2;
    localparam int DEF_COLS       = 4;
    localparam int DEF_WORD_WIDTH = 8;

    // Column counter width for the default geometry (counts 0..COLS).
    localparam int CNT_W = $clog2(DEF_COLS + 1);

    // Column counter width for an arbitrary column count.
    function automatic int cnt_width(input int cols);
        return $clog2(cols + 1);
    endfunction

endpackage

// File: rtl/axis_in_gather.sv
// Column gatherer: packs COLS single-column beats into one COLS x ROWS word.
// The first column of a group ends up at index COLS-1; short packets are
// zero-padded so their first column is still left-aligned.
module axis_in_gather
    import axis_in_gather_pkg::*;
#(
    parameter int ROWS       = DEF_ROWS,
    parameter int COLS       = DEF_COLS,
    parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
    input  logic                                         aclk,
    input  logic                                         rst,
    input  logic                                         s_valid,
    output logic                                         s_ready,
    input  logic [ROWS-1:0][WORD_WIDTH-1:0]              s_data,
    input  logic                                         s_last,
    output logic                                         m_valid,
    input  logic                                         m_ready,
    output logic [COLS-1:0][ROWS-1:0][WORD_WIDTH-1:0]    m_data,
    output logic [COLS-1:0]                              m_col_valid,
    output logic                                         m_last
);

    localparam int CW = cnt_width(COLS);

    typedef logic [COLS-1:0][ROWS-1:0][WORD_WIDTH-1:0] word_t;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    word_t           shreg_q, shreg_d;
    logic [COLS-1:0] vmask_q, vmask_d;
    logic            last_q, last_d;
    logic            s_ready_q, m_valid_q, m_last_q;

    // Next-state logic: shift columns in at index 0, pad short groups, hold the word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        vmask_d = vmask_q;
        last_d  = last_q;
        case (state_q)
            COLLECT: begin
                // s_ready is registered high in this state, so s_valid alone is the handshake.
                if (s_valid) begin
                    shreg_d = {shreg_q[COLS-2:0], s_data};
                    vmask_d = {vmask_q[COLS-2:0], 1'b1};
                    if (cnt_q == CW'(COLS - 1)) begin
                        state_d = HOLD;
                        last_d  = s_last;
                        cnt_d   = '0;
                    end else if (s_last) begin
                        state_d = PAD;
                        last_d  = 1'b1;
                        cnt_d   = cnt_q + CW'(1);
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            end
            PAD: begin
                // Push zero columns until the group is COLS wide.
                shreg_d = {shreg_q[COLS-2:0], {(ROWS*WORD_WIDTH){1'b0}}};
                vmask_d = {vmask_q[COLS-2:0], 1'b0};
                if (cnt_q == CW'(COLS - 1)) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                if (m_ready) begin
                    state_d = COLLECT;
                    vmask_d = '0;
                    last_d  = 1'b0;
                end
            end
            default: begin
                state_d = COLLECT;
                cnt_d   = '0;
            end
        endcase
    end

    // State and registered handshake outputs; reset drops any partial group.
    always_ff @(posedge aclk) begin
        if (rst) begin
            state_q   <= COLLECT;
            cnt_q     <= '0;
            shreg_q   <= '0;
            vmask_q   <= '0;
            last_q    <= 1'b0;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            vmask_q   <= vmask_d;
            last_q    <= last_d;
            s_ready_q <= (state_d == COLLECT);
            m_valid_q <= (state_d == HOLD);
            m_last_q  <= (state_d == HOLD) && last_d;
        end
    end

    assign s_ready     = s_ready_q;
    assign m_valid     = m_valid_q;
    assign m_last      = m_last_q;
    assign m_data      = shreg_q;
    assign m_col_valid = vmask_q;

endmodule
